nysa_host_response_tx: RTL and testbench

Transmit side of the Nysa host interface in the SDIO device. Takes responses from the Nysa master's output-handshake port (status, address, word count, data words) and serialises them, one byte per cycle, into the framed byte stream that the SDIO function block returns to the host. It is the counterpart of the command-receive path: the receiver turns host bytes into master commands, and this block turns master responses into host bytes.

---
 rtl/nysa_host_pkg.sv | 14 +
 rtl/nysa_word_serializer.sv | 40 ++++
 rtl/nysa_host_response_tx.sv | 140 ++++++++++++++
 tb/tb_nysa_host_response_tx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/nysa_host_pkg.sv
// Shared definitions for the Nysa host interface transmit and receive paths.
package nysa_host_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HDR       = 2'd1,
        DATA      = 2'd2,
        WAIT_WORD = 2'd3
    } state_t;

    localparam int         HDR_BYTES       = 13;
    localparam logic [7:0] DEFAULT_ID_BYTE = 8'hCD;

endpackage

// File: rtl/nysa_word_serializer.sv
// Loads a word and shifts it out MSB-first, one byte per advance; i_len is the
// index of the final byte so a single-byte field (the ID byte) uses the same path.
module nysa_word_serializer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_word,
    input  logic [1:0]  i_len,
    input  logic        i_adv,
    output logic [7:0]  o_byte,
    output logic        o_last
);

    logic [7:0]  r_byte;
    logic [23:0] r_rest;
    logic [1:0]  r_idx;
    logic [1:0]  r_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte <= 8'h00;
            r_rest <= 24'h0;
            r_idx  <= 2'd0;
            r_len  <= 2'd0;
        end else if (i_load) begin
            r_byte <= i_word[31:24];
            r_rest <= i_word[23:0];
            r_idx  <= 2'd0;
            r_len  <= i_len;
        end else if (i_adv) begin
            r_byte <= r_rest[23:16];
            r_rest <= {r_rest[15:0], 8'h00};
            r_idx  <= r_idx + 2'd1;
        end
    end

    assign o_byte = r_byte;
    assign o_last = (r_idx == r_len);

endmodule

// File: rtl/nysa_host_response_tx.sv
// Serialises Nysa master responses (status, count, address, data words) into
// the framed big-endian byte stream returned to the host, one byte per transfer.
module nysa_host_response_tx
    import nysa_host_pkg::*;
#(
    parameter logic [7:0] ID_BYTE = DEFAULT_ID_BYTE,
    parameter int         COUNT_W = 28
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_oh_en,
    output logic               o_oh_ready,
    input  logic [31:0]        i_status,
    input  logic [31:0]        i_address,
    input  logic [COUNT_W-1:0] i_data_count,
    input  logic [31:0]        i_data,
    output logic [7:0]         o_tx_byte,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy
);

    state_t               r_state, w_state_nxt;
    logic [3:0]           r_hdr_idx, w_hdr_idx_nxt;
    logic [COUNT_W-1:0]   r_rem, w_rem_nxt;
    logic [31:0]          r_status, r_address, r_data;
    logic [COUNT_W-1:0]   r_count;
    logic                 r_tx_valid, r_oh_ready, r_busy;

    logic                 w_accept, w_xfer, w_first;
    logic                 w_ld, w_adv, w_ser_last;
    logic [31:0]          w_ld_word;
    logic [1:0]           w_ld_len;

    assign w_accept = i_oh_en & r_oh_ready;
    assign w_xfer   = r_tx_valid & i_tx_ready;
    assign w_first  = w_accept & (r_state == IDLE);

    always_comb begin
        w_state_nxt   = r_state;
        w_hdr_idx_nxt = r_hdr_idx;
        w_rem_nxt     = r_rem;
        w_ld          = 1'b0;
        w_adv         = 1'b0;
        w_ld_word     = 32'h0;
        w_ld_len      = 2'd3;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_ld          = 1'b1;
                    w_ld_word     = {ID_BYTE, 24'h0};
                    w_ld_len      = 2'd0;
                    w_hdr_idx_nxt = 4'd0;
                    w_rem_nxt     = (i_data_count == '0) ? '0 : i_data_count - COUNT_W'(1);
                    w_state_nxt   = HDR;
                end
            end
            HDR: begin
                if (w_xfer) begin
                    w_hdr_idx_nxt = r_hdr_idx + 4'd1;
                    if (w_ser_last) begin
                        // Field boundary: the byte just sent closes ID, status, count or address.
                        w_ld = 1'b1;
                        case (r_hdr_idx)
                            4'd0:    w_ld_word = r_status;
                            4'd4:    w_ld_word = 32'(r_count);
                            4'd8:    w_ld_word = r_address;
                            default: w_ld_word = r_data;
                        endcase
                        if (r_hdr_idx == 4'(HDR_BYTES - 1))
                            w_state_nxt = DATA;
                    end else begin
                        w_adv = 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_xfer) begin
                    if (w_ser_last)
                        w_state_nxt = (r_rem != '0) ? WAIT_WORD : IDLE;
                    else
                        w_adv = 1'b1;
                end
            end
            WAIT_WORD: begin
                if (w_accept) begin
                    w_ld        = 1'b1;
                    w_ld_word   = i_data;
                    w_rem_nxt   = (r_rem != '0) ? r_rem - COUNT_W'(1) : r_rem;
                    w_state_nxt = DATA;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_hdr_idx  <= 4'd0;
            r_rem      <= '0;
            r_status   <= 32'h0;
            r_address  <= 32'h0;
            r_count    <= '0;
            r_data     <= 32'h0;
            r_tx_valid <= 1'b0;
            r_oh_ready <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hdr_idx  <= w_hdr_idx_nxt;
            r_rem      <= w_rem_nxt;
            if (w_first) begin
                r_status  <= i_status;
                r_address <= i_address;
                r_count   <= i_data_count;
                r_data    <= i_data;
            end
            r_tx_valid <= (w_state_nxt == HDR) || (w_state_nxt == DATA);
            r_oh_ready <= (w_state_nxt == IDLE) || (w_state_nxt == WAIT_WORD);
            r_busy     <= (w_state_nxt != IDLE);
        end
    end

    nysa_word_serializer u_ser (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_ld),
        .i_word (w_ld_word),
        .i_len  (w_ld_len),
        .i_adv  (w_adv),
        .o_byte (o_tx_byte),
        .o_last (w_ser_last)
    );

    assign o_tx_valid = r_tx_valid;
    assign o_oh_ready = r_oh_ready;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_nysa_host_response_tx.sv
// Randomised bench for nysa_host_response_tx with a byte-queue frame model.
module tb_nysa_host_response_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_oh_en;
    logic        o_oh_ready;
    logic [31:0] i_status, i_address, i_data;
    logic [27:0] i_data_count;
    logic [7:0]  o_tx_byte;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic        o_busy;

    int          checks = 0;
    int          errors = 0;
    bit          bp = 1'b0;
    int          wait_acc;
    logic [31:0] words[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  cap[$];
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_byte;

    nysa_host_response_tx dut (
        .clk          (clk),
        .rst          (rst),
        .i_oh_en      (i_oh_en),
        .o_oh_ready   (o_oh_ready),
        .i_status     (i_status),
        .i_address    (i_address),
        .i_data_count (i_data_count),
        .i_data       (i_data),
        .o_tx_byte    (o_tx_byte),
        .o_tx_valid   (o_tx_valid),
        .i_tx_ready   (i_tx_ready),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Frame model: header fields big-endian, then every queued word.
    task automatic model_frame(input logic [31:0] st, input logic [31:0] ad, input logic [27:0] n);
        logic [31:0] cnt;
        cnt = {4'h0, n};
        exp_q.delete();
        exp_q.push_back(8'hCD);
        for (int b = 3; b >= 0; b--) exp_q.push_back(st[8*b +: 8]);
        for (int b = 3; b >= 0; b--) exp_q.push_back(cnt[8*b +: 8]);
        for (int b = 3; b >= 0; b--) exp_q.push_back(ad[8*b +: 8]);
        foreach (words[w])
            for (int b = 3; b >= 0; b--) exp_q.push_back(words[w][8*b +: 8]);
    endtask

    initial begin
        i_tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            i_tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", {31'h0, o_tx_valid}, 32'h1);
                check("stall_byte", {24'h0, o_tx_byte}, {24'h0, prev_byte});
            end
            prev_stall = o_tx_valid && !i_tx_ready;
            prev_byte  = o_tx_byte;
            if (o_tx_valid && i_tx_ready) cap.push_back(o_tx_byte);
        end
    end

    task automatic offer(input logic [31:0] st, input logic [31:0] ad,
                         input logic [27:0] n, input logic [31:0] d);
        int cyc = 0;
        i_oh_en = 1'b1; i_status = st; i_address = ad; i_data_count = n; i_data = d;
        while (!o_oh_ready && cyc < 400) begin
            @(posedge clk); #3; cyc++;
        end
        if (!o_oh_ready) check("offer_timeout", {31'h0, o_oh_ready}, 32'h1);
        if (o_busy) wait_acc++;
        @(posedge clk); #3;
        i_oh_en = 1'b0;
    endtask

    task automatic wait_bytes(input int n);
        int cyc = 0;
        while (cap.size() < n && cyc < 3000) begin
            @(posedge clk); #3; cyc++;
        end
        if (cap.size() < n) check("byte_timeout", cap.size(), n);
    endtask

    task automatic compare(input string tag, input int n);
        check({tag, "_len"}, cap.size(), n);
        for (int i = 0; i < n && i < cap.size() && i < exp_q.size(); i++)
            check($sformatf("%s_b%0d", tag, i), {24'h0, cap[i]}, {24'h0, exp_q[i]});
    endtask

    task automatic run_frame(input string tag, input logic [31:0] st, input logic [31:0] ad,
                             input logic [27:0] n);
        cap.delete();
        wait_acc = 0;
        model_frame(st, ad, n);
        foreach (words[w]) begin
            if (w == 0) offer(st, ad, n, words[w]);
            else        offer($urandom, $urandom, 28'($urandom), words[w]);
        end
        wait_bytes(exp_q.size());
        compare(tag, exp_q.size());
        check({tag, "_wait_acc"}, wait_acc, words.size() - 1);
        check({tag, "_end_busy"}, {31'h0, o_busy}, 32'h0);
        check({tag, "_end_ready"}, {31'h0, o_oh_ready}, 32'h1);
        check({tag, "_end_valid"}, {31'h0, o_tx_valid}, 32'h0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_valid"}, {31'h0, o_tx_valid}, 32'h0);
        check({tag, "_busy"}, {31'h0, o_busy}, 32'h0);
        check({tag, "_ready"}, {31'h0, o_oh_ready}, 32'h1);
        check({tag, "_byte"}, {24'h0, o_tx_byte}, 32'h0);
        @(posedge clk); #3;
        rst = 1'b0;
        cap.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i_oh_en = 1'b0; i_status = '0; i_address = '0;
        i_data_count = '0; i_data = '0;
        repeat (2) @(posedge clk);
        #3;
        do_reset("rst0");

        words = '{32'h12345678};
        run_frame("ping", 32'h00000001, 32'h0, 28'd0);

        words = '{32'hAABBCCDD, 32'h11223344, 32'h55667788};
        run_frame("read3", 32'h0, 32'h00000100, 28'd3);

        bp = 1'b1;
        run_frame("read3_bp", 32'h0, 32'h00000100, 28'd3);
        bp = 1'b0;

        // Strobe during the header with different fields must be ignored.
        words = '{32'h12345678};
        cap.delete();
        model_frame(32'h00000001, 32'h0, 28'd0);
        offer(32'h00000001, 32'h0, 28'd0, 32'h12345678);
        @(posedge clk); #3;
        i_oh_en = 1'b1; i_status = 32'hDEADBEEF; i_data = 32'hCAFEF00D; i_data_count = 28'd5;
        check("strobe_ready", {31'h0, o_oh_ready}, 32'h0);
        @(posedge clk); #3;
        i_oh_en = 1'b0;
        wait_bytes(exp_q.size());
        compare("strobe", exp_q.size());
        check("strobe_end_ready", {31'h0, o_oh_ready}, 32'h1);

        // Reset after byte 7 of a frame, then a clean ping.
        cap.delete();
        offer(32'h00000001, 32'h0, 28'd0, 32'h12345678);
        wait_bytes(7);
        do_reset("rst_mid");
        words = '{32'h12345678};
        run_frame("ping2", 32'h00000001, 32'h0, 28'd0);

        for (int k = 0; k < 4; k++) begin
            int n;
            n = $urandom_range(0, 4);
            words.delete();
            for (int w = 0; w < ((n == 0) ? 1 : n); w++) words.push_back($urandom);
            bp = 1'($urandom_range(0, 1));
            run_frame($sformatf("rnd%0d", k), $urandom, $urandom, 28'(n));
        end
        bp = 1'b0;

        // Maximum count: two words then abort.
        words = '{$urandom, $urandom};
        cap.delete();
        wait_acc = 0;
        model_frame(32'hA5A5A5A5, 32'h00001000, 28'hFFFFFFF);
        offer(32'hA5A5A5A5, 32'h00001000, 28'hFFFFFFF, words[0]);
        offer($urandom, $urandom, 28'd1, words[1]);
        wait_bytes(21);
        compare("maxcnt", 21);
        if (cap.size() >= 9) begin
            check("maxcnt_c0", {24'h0, cap[5]}, 32'h0F);
            check("maxcnt_c1", {24'h0, cap[6]}, 32'hFF);
            check("maxcnt_c2", {24'h0, cap[7]}, 32'hFF);
            check("maxcnt_c3", {24'h0, cap[8]}, 32'hFF);
        end
        check("maxcnt_wait_ready", {31'h0, o_oh_ready}, 32'h1);
        check("maxcnt_wait_busy", {31'h0, o_busy}, 32'h1);
        check("maxcnt_wait_acc", wait_acc, 1);
        do_reset("rst_max");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
